// File: rtl/microwave_timer.sv
// microwave_timer: keypad-loaded MM:SS BCD countdown that sits upstream of the
// magnetron controller. Digits shift in from the right; the count decrements
// once per second while mag_on is high and timer_done flags 00:00.
// Optional feature: define MICROWAVE_DONE_BEEP_EN to add the DONE state and the
// beep output that sounds for BEEP_SECS seconds after the count expires.
module microwave_timer #(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int BEEP_SECS     = 3
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       clearn,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       mag_on,
`ifdef MICROWAVE_DONE_BEEP_EN
  output logic       beep,
`endif
  output logic       timer_done,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones
);

  localparam int            PW       = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_SEC - 1);
`ifdef MICROWAVE_DONE_BEEP_EN
  localparam int            BW        = (BEEP_SECS > 1) ? $clog2(BEEP_SECS) : 1;
  localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_SECS - 1);
`endif

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_RUNNING = 2'd2
`ifdef MICROWAVE_DONE_BEEP_EN
    ,
    ST_DONE    = 2'd3
`endif
  } state_t;

  state_t        state_r, state_s;
  logic [PW-1:0] pre_r, pre_s;
  logic [15:0]   count_r, count_s;
  logic          done_r, done_s;
  logic          key_ok_s;
  logic          tick_s;
  logic [15:0]   entered_s;
  logic [15:0]   dec_s;
`ifdef MICROWAVE_DONE_BEEP_EN
  logic          beep_r, beep_s;
  logic [BW-1:0] bcnt_r, bcnt_s;
`endif

  // One-second BCD decrement with digit borrow; 00:00 holds.
  function automatic logic [15:0] bcd_dec(input logic [15:0] cnt);
    logic [3:0] mt, mo, st, so;
    mt = cnt[15:12];
    mo = cnt[11:8];
    st = cnt[7:4];
    so = cnt[3:0];
    if (so != 4'd0) begin
      so = so - 4'd1;
    end else if (st != 4'd0) begin
      st = st - 4'd1;
      so = 4'd9;
    end else if (mo != 4'd0) begin
      mo = mo - 4'd1;
      st = 4'd5;
      so = 4'd9;
    end else if (mt != 4'd0) begin
      mt = mt - 4'd1;
      mo = 4'd9;
      st = 4'd5;
      so = 4'd9;
    end else begin
      mt = 4'd0;
      mo = 4'd0;
      st = 4'd0;
      so = 4'd0;
    end
    return {mt, mo, st, so};
  endfunction

  // Next-state, next-count and prescaler logic; clear overrides everything.
  always_comb begin
    state_s   = state_r;
    pre_s     = pre_r;
    count_s   = count_r;
`ifdef MICROWAVE_DONE_BEEP_EN
    beep_s    = beep_r;
    bcnt_s    = bcnt_r;
`endif
    key_ok_s  = key_valid && (key_digit <= 4'd9);
    tick_s    = (pre_r == PRE_LAST);
    entered_s = {count_r[11:0], key_digit};
    dec_s     = bcd_dec(count_r);

    if (!clearn) begin
      state_s = ST_IDLE;
      pre_s   = '0;
      count_s = 16'd0;
`ifdef MICROWAVE_DONE_BEEP_EN
      beep_s  = 1'b0;
      bcnt_s  = '0;
`endif
    end else begin
      case (state_r)
        ST_IDLE, ST_ARMED: begin
          pre_s = '0;
          if (key_ok_s) begin
            // A key on the same edge as mag_on wins; running starts next edge.
            count_s = entered_s;
            state_s = (entered_s != 16'd0) ? ST_ARMED : ST_IDLE;
          end else if ((state_r == ST_ARMED) && mag_on) begin
            state_s = ST_RUNNING;
          end else begin
            state_s = state_r;
          end
        end
        ST_RUNNING: begin
          if (tick_s) begin
            // The decrement lands even if mag_on drops on this same edge.
            count_s = dec_s;
            pre_s   = '0;
            if (dec_s == 16'd0) begin
`ifdef MICROWAVE_DONE_BEEP_EN
              state_s = ST_DONE;
              beep_s  = 1'b1;
              bcnt_s  = '0;
`else
              state_s = ST_IDLE;
`endif
            end else if (!mag_on) begin
              state_s = ST_ARMED;
            end else begin
              state_s = ST_RUNNING;
            end
          end else if (!mag_on) begin
            // Pause throws away the partial second.
            state_s = ST_ARMED;
            pre_s   = '0;
          end else begin
            pre_s = pre_r + PW'(1'b1);
          end
        end
`ifdef MICROWAVE_DONE_BEEP_EN
        ST_DONE: begin
          if (key_ok_s) begin
            count_s = entered_s;
            state_s = (entered_s != 16'd0) ? ST_ARMED : ST_IDLE;
            pre_s   = '0;
            beep_s  = 1'b0;
            bcnt_s  = '0;
          end else if (tick_s) begin
            pre_s = '0;
            if (bcnt_r == BEEP_LAST) begin
              state_s = ST_IDLE;
              beep_s  = 1'b0;
              bcnt_s  = '0;
            end else begin
              bcnt_s = bcnt_r + BW'(1'b1);
            end
          end else begin
            pre_s = pre_r + PW'(1'b1);
          end
        end
`endif
        default: begin
          state_s = ST_IDLE;
          pre_s   = '0;
          count_s = 16'd0;
        end
      endcase
    end

    done_s = (count_s == 16'd0);
  end

  // State, count and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
      pre_r   <= '0;
      count_r <= 16'd0;
      done_r  <= 1'b1;
`ifdef MICROWAVE_DONE_BEEP_EN
      beep_r  <= 1'b0;
      bcnt_r  <= '0;
`endif
    end else begin
      state_r <= state_s;
      pre_r   <= pre_s;
      count_r <= count_s;
      done_r  <= done_s;
`ifdef MICROWAVE_DONE_BEEP_EN
      beep_r  <= beep_s;
      bcnt_r  <= bcnt_s;
`endif
    end
  end

  assign {min_tens, min_ones, sec_tens, sec_ones} = count_r;
  assign timer_done = done_r;
`ifdef MICROWAVE_DONE_BEEP_EN
  assign beep = beep_r;
`endif

endmodule

// File: tb/tb_microwave_timer.sv
// Bench for microwave_timer: a minutes/seconds model kept as plain integers,
// compared against the DUT after every clock, plus literal expectations for
// the directed scenarios and a randomized stimulus phase.
module tb_microwave_timer;

  localparam int T  = 4;
  localparam int BS = 3;

  logic       clk = 1'b0;
  logic       resetn;
  logic       clearn;
  logic       key_valid;
  logic [3:0] key_digit;
  logic       mag_on;
  logic       timer_done;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
`ifdef MICROWAVE_DONE_BEEP_EN
  logic       beep_w;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: count as integer minutes and seconds.
  int m_min, m_sec, m_phase, m_beep_left;
  bit m_running;
  logic mag_lvl;

  microwave_timer #(.TICKS_PER_SEC(T), .BEEP_SECS(BS)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .clearn     (clearn),
    .key_valid  (key_valid),
    .key_digit  (key_digit),
    .mag_on     (mag_on),
`ifdef MICROWAVE_DONE_BEEP_EN
    .beep       (beep_w),
`endif
    .timer_done (timer_done),
    .min_tens   (min_tens),
    .min_ones   (min_ones),
    .sec_tens   (sec_tens),
    .sec_ones   (sec_ones)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  function automatic int dut_cnt();
    return int'({min_tens, min_ones, sec_tens, sec_ones});
  endfunction

  task automatic cmp(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_enter(input int d);
    int v;
    v = ((m_min * 100 + m_sec) * 10 + d) % 10000;
    m_min = v / 100;
    m_sec = v % 100;
  endtask

  task automatic model_update(input logic rn, input logic cn, input logic kv,
                              input logic [3:0] kd, input logic mg);
    bit key_ok;
    key_ok = kv && (kd <= 4'd9);
    if (!rn || !cn) begin
      m_min = 0; m_sec = 0; m_running = 0; m_phase = 0; m_beep_left = 0;
    end else if (m_running) begin
      m_phase++;
      if (m_phase == T) begin
        m_phase = 0;
        if (m_sec > 0) m_sec--;
        else if (m_min > 0) begin m_min--; m_sec = 59; end
        if (m_min == 0 && m_sec == 0) begin
          m_running = 0;
`ifdef MICROWAVE_DONE_BEEP_EN
          m_beep_left = BS * T;
`endif
        end else if (!mg) m_running = 0;
      end else if (!mg) begin
        m_running = 0;
        m_phase = 0;
      end
    end else if (m_beep_left > 0) begin
      if (key_ok) begin
        model_enter(int'(kd));
        m_beep_left = 0;
      end else m_beep_left--;
    end else begin
      if (key_ok) model_enter(int'(kd));
      else if (mg && (m_min != 0 || m_sec != 0)) begin
        m_running = 1;
        m_phase = 0;
      end
    end
  endtask

  task automatic check_model();
    int exp_cnt;
    exp_cnt = int'({4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10)});
    cmp("count", dut_cnt(), exp_cnt);
    cmp("timer_done", int'(timer_done), (m_min == 0 && m_sec == 0) ? 1 : 0);
`ifdef MICROWAVE_DONE_BEEP_EN
    cmp("beep", int'(beep_w), (m_beep_left > 0) ? 1 : 0);
`endif
  endtask

  // One clock: drive inputs, let the edge happen, advance model, compare.
  task automatic step(input logic rn, input logic cn, input logic kv,
                      input logic [3:0] kd, input logic mg);
    resetn = rn; clearn = cn; key_valid = kv; key_digit = kd; mag_on = mg;
    @(posedge clk);
    model_update(rn, cn, kv, kd, mg);
    #1;
    check_model();
  endtask

  task automatic key(input logic [3:0] d);
    step(1'b1, 1'b1, 1'b1, d, mag_lvl);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, 4'd0, mag_lvl);
  endtask

  task automatic clear();
    step(1'b1, 1'b0, 1'b0, 4'd0, mag_lvl);
  endtask

  initial begin
    resetn = 1'b0; clearn = 1'b1; key_valid = 1'b0; key_digit = 4'd0; mag_on = 1'b0;
    m_min = 0; m_sec = 0; m_phase = 0; m_beep_left = 0; m_running = 0;
    mag_lvl = 1'b0;

    // Reset and key entry.
    step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    cmp("reset_digits", dut_cnt(), 32'h0000);
    cmp("reset_done", int'(timer_done), 1);
`ifdef MICROWAVE_DONE_BEEP_EN
    cmp("reset_beep", int'(beep_w), 0);
`endif
    key(4'd1);
    cmp("first_key_done", int'(timer_done), 0);
    key(4'd3);
    key(4'd0);
    cmp("keys_0130", dut_cnt(), 32'h0130);

    // 01:00 running: first decrement, then ten more seconds.
    clear();
    key(4'd1); key(4'd0); key(4'd0);
    mag_lvl = 1'b1;
    idle(1);
    idle(4);
    cmp("run_0059", dut_cnt(), 32'h0059);
    idle(40);
    cmp("run_0049", dut_cnt(), 32'h0049);
    mag_lvl = 1'b0;
    idle(1);
    clear();

    // 00:02 to expiry.
    key(4'd0); key(4'd2);
    mag_lvl = 1'b1;
    idle(1);
    idle(4);
    cmp("exp_0001", dut_cnt(), 32'h0001);
    idle(4);
    cmp("exp_0000", dut_cnt(), 32'h0000);
    cmp("exp_done", int'(timer_done), 1);
`ifdef MICROWAVE_DONE_BEEP_EN
    cmp("beep_on", int'(beep_w), 1);
    idle(11);
    cmp("beep_last", int'(beep_w), 1);
    idle(1);
    cmp("beep_off", int'(beep_w), 0);
`endif
    idle(6);
    cmp("idle_mag_done", int'(timer_done), 1);
    mag_lvl = 1'b0;
    clear();

    // Pause and resume.
    key(4'd5);
    mag_lvl = 1'b1;
    idle(1);
    idle(6);
    mag_lvl = 1'b0;
    idle(10);
    cmp("pause_hold", dut_cnt(), 32'h0004);
    mag_lvl = 1'b1;
    idle(1);
    idle(3);
    cmp("resume_early", dut_cnt(), 32'h0004);
    idle(1);
    cmp("resume_dec", dut_cnt(), 32'h0003);

    // Keys ignored while running; clear beats key.
    key(4'd7);
    cmp("run_key_ign", dut_cnt(), 32'h0003);
    step(1'b1, 1'b0, 1'b1, 4'd7, mag_lvl);
    cmp("clear_key", dut_cnt(), 32'h0000);
    cmp("clear_done", int'(timer_done), 1);
    idle(6);
    cmp("clear_idle", dut_cnt(), 32'h0000);
    mag_lvl = 1'b0;

    // Invalid digit, then 00:90.
    key(4'd5);
    key(4'd12);
    cmp("bad_digit", dut_cnt(), 32'h0005);
    clear();
    key(4'd9); key(4'd0);
    cmp("load_0090", dut_cnt(), 32'h0090);
    mag_lvl = 1'b1;
    idle(1);
    idle(16);
    cmp("run_0086", dut_cnt(), 32'h0086);
    mag_lvl = 1'b0;
    clear();

    // Randomized phase.
    for (int i = 0; i < 12000; i++) begin
      logic rn, cn, kv;
      logic [3:0] kd;
      rn = ($urandom_range(0, 1499) != 0);
      cn = ($urandom_range(0, 399) != 0);
      kv = ($urandom_range(0, 14) == 0);
      kd = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
      if ($urandom_range(0, 24) == 0) mag_lvl = ~mag_lvl;
      step(rn, cn, kv, kd, mag_lvl);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
